// File: rtl/spi_regfile.sv
// Register bank behind the SPI register-access slave: config registers with write-lock,
// a read-only hw snapshot, sticky error flags, a write counter and fast-command actions.
module spi_regfile #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned REG_W  = 8
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic [ADDR_W-1:0]              reg_addr,
  input  logic [REG_W-1:0]               wr_data,
  input  logic                           wr_vld,
  output logic [REG_W-1:0]               rd_data,
  input  logic [5:0]                     fastcmd,
  input  logic                           fastcmd_vld,
  output logic [7:0]                     status,
  input  logic [REG_W-1:0]               hw_in,
  output logic [(2**ADDR_W)*REG_W-1:0]   cfg,
  output logic                           irq
);

  localparam int unsigned NUM_REGS = 2**ADDR_W;
  localparam int unsigned SNAP_IDX = NUM_REGS - 1;
  localparam int unsigned LOCK_BIT = 7;
  localparam int unsigned WCNT_W   = 4;

  localparam logic [5:0] CMD_SOFTRST  = 6'h00;
  localparam logic [5:0] CMD_SNAPSHOT = 6'h01;
  localparam logic [5:0] CMD_CLRFLAGS = 6'h02;

  logic [REG_W-1:0]  r_regs [NUM_REGS];
  logic [WCNT_W-1:0] r_wcnt;
  logic              r_werr;
  logic              r_ucmd;
  logic              r_svld;

  logic w_lock;
  logic w_softrst;
  logic w_snapshot;
  logic w_clrflags;
  logic w_unknown;
  logic w_addr_ctrl;
  logic w_addr_snap;
  logic w_wr_ok;
  logic w_wr_fault;

  // Command decode and write qualification; a same-cycle soft reset swallows the write.
  always_comb begin
    w_lock      = r_regs[0][LOCK_BIT];
    w_softrst   = fastcmd_vld && (fastcmd == CMD_SOFTRST);
    w_snapshot  = fastcmd_vld && (fastcmd == CMD_SNAPSHOT);
    w_clrflags  = fastcmd_vld && (fastcmd == CMD_CLRFLAGS);
    w_unknown   = fastcmd_vld && !w_softrst && !w_snapshot && !w_clrflags;
    w_addr_ctrl = (reg_addr == ADDR_W'(0));
    w_addr_snap = (reg_addr == ADDR_W'(SNAP_IDX));
    w_wr_ok     = wr_vld && !w_softrst && (w_addr_ctrl || (!w_addr_snap && !w_lock));
    w_wr_fault  = wr_vld && !w_softrst && !w_wr_ok;
  end

  // R/W register array; the snapshot slot is only loaded from hw_in.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(SNAP_IDX); i++) begin
        if (w_softrst) begin
          r_regs[i] <= '0;
        end else if (w_wr_ok && (reg_addr == ADDR_W'(i))) begin
          r_regs[i] <= wr_data;
        end
      end
      if (w_snapshot) begin
        r_regs[SNAP_IDX] <= hw_in;
      end
    end
  end

  // Write counter, sticky flags and snapshot-valid.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wcnt <= '0;
      r_werr <= 1'b0;
      r_ucmd <= 1'b0;
      r_svld <= 1'b0;
    end else begin
      if (w_softrst) begin
        r_wcnt <= '0;
      end else if (w_wr_ok) begin
        r_wcnt <= r_wcnt + WCNT_W'(1);
      end

      // A faulting write beats a same-cycle CLRFLAGS.
      if (w_softrst) begin
        r_werr <= 1'b0;
      end else if (w_wr_fault) begin
        r_werr <= 1'b1;
      end else if (w_clrflags) begin
        r_werr <= 1'b0;
      end

      if (w_softrst || w_clrflags) begin
        r_ucmd <= 1'b0;
      end else if (w_unknown) begin
        r_ucmd <= 1'b1;
      end

      if (w_snapshot) begin
        r_svld <= 1'b1;
      end else if (w_clrflags) begin
        r_svld <= 1'b0;
      end
    end
  end

  // Registered read port; samples the contents present before this edge's write.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_data <= '0;
    end else begin
      rd_data <= r_regs[reg_addr];
    end
  end

  always_comb begin
    cfg = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      cfg[i*int'(REG_W) +: REG_W] = r_regs[i];
    end
  end

  assign status = {w_lock, r_werr, r_ucmd, r_svld, r_wcnt};
  assign irq    = r_werr | r_ucmd;

endmodule

// File: tb/tb_spi_regfile.sv
// Directed bench for spi_regfile: vector table for single-cycle events plus
// hand sequences for held strobes, read latency, address increment and async reset.
module tb_spi_regfile;

  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned REG_W    = 8;
  localparam int unsigned NUM_REGS = 8;

  logic                        clk = 1'b0;
  logic                        nrst;
  logic [ADDR_W-1:0]           reg_addr;
  logic [REG_W-1:0]            wr_data;
  logic                        wr_vld;
  logic [REG_W-1:0]            rd_data;
  logic [5:0]                  fastcmd;
  logic                        fastcmd_vld;
  logic [7:0]                  status;
  logic [REG_W-1:0]            hw_in;
  logic [NUM_REGS*REG_W-1:0]   cfg;
  logic                        irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_regfile #(.ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .reg_addr    (reg_addr),
    .wr_data     (wr_data),
    .wr_vld      (wr_vld),
    .rd_data     (rd_data),
    .fastcmd     (fastcmd),
    .fastcmd_vld (fastcmd_vld),
    .status      (status),
    .hw_in       (hw_in),
    .cfg         (cfg),
    .irq         (irq)
  );

  typedef struct {
    logic       wv;
    logic [2:0] a;
    logic [7:0] d;
    logic       fv;
    logic [5:0] fc;
    logic [7:0] hw;
    logic [2:0] ci;
    logic [7:0] ecfg;
    logic [7:0] est;
    logic       eirq;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] cfg_byte(input logic [2:0] idx);
    return cfg[int'(idx)*8 +: 8];
  endfunction

  task automatic drive(input logic wv, input logic [2:0] a, input logic [7:0] d,
                       input logic fv, input logic [5:0] fc, input logic [7:0] hw);
    wr_vld      = wv;
    reg_addr    = a;
    wr_data     = d;
    fastcmd_vld = fv;
    fastcmd     = fc;
    hw_in       = hw;
  endtask

  initial begin
    //           wv    a     d      fv    fc     hw     ci    ecfg   est    irq
    vecs[0]  = '{1'b1, 3'd2, 8'hA5, 1'b0, 6'h00, 8'h00, 3'd2, 8'hA5, 8'h01, 1'b0};
    vecs[1]  = '{1'b1, 3'd0, 8'h80, 1'b0, 6'h00, 8'h00, 3'd0, 8'h80, 8'h82, 1'b0};
    vecs[2]  = '{1'b1, 3'd3, 8'h33, 1'b0, 6'h00, 8'h00, 3'd3, 8'h00, 8'hC2, 1'b1};
    vecs[3]  = '{1'b1, 3'd0, 8'h00, 1'b0, 6'h00, 8'h00, 3'd0, 8'h00, 8'h43, 1'b1};
    vecs[4]  = '{1'b1, 3'd3, 8'h33, 1'b0, 6'h00, 8'h00, 3'd3, 8'h33, 8'h44, 1'b1};
    vecs[5]  = '{1'b0, 3'd0, 8'h00, 1'b1, 6'h02, 8'h00, 3'd3, 8'h33, 8'h04, 1'b0};
    vecs[6]  = '{1'b0, 3'd0, 8'h00, 1'b1, 6'h01, 8'h5C, 3'd7, 8'h5C, 8'h14, 1'b0};
    vecs[7]  = '{1'b1, 3'd7, 8'hAA, 1'b0, 6'h00, 8'h00, 3'd7, 8'h5C, 8'h54, 1'b1};
    vecs[8]  = '{1'b0, 3'd0, 8'h00, 1'b1, 6'h02, 8'h00, 3'd7, 8'h5C, 8'h04, 1'b0};
    vecs[9]  = '{1'b0, 3'd0, 8'h00, 1'b1, 6'h3F, 8'h00, 3'd7, 8'h5C, 8'h24, 1'b1};
    vecs[10] = '{1'b1, 3'd1, 8'hFF, 1'b1, 6'h00, 8'h00, 3'd1, 8'h00, 8'h00, 1'b0};
    vecs[11] = '{1'b0, 3'd0, 8'h00, 1'b0, 6'h00, 8'h00, 3'd2, 8'h00, 8'h00, 1'b0};
    vecs[12] = '{1'b0, 3'd0, 8'h00, 1'b1, 6'h01, 8'h3C, 3'd7, 8'h3C, 8'h10, 1'b0};
    vecs[13] = '{1'b1, 3'd7, 8'h11, 1'b1, 6'h02, 8'h00, 3'd7, 8'h3C, 8'h40, 1'b1};
    vecs[14] = '{1'b1, 3'd5, 8'h66, 1'b1, 6'h01, 8'h77, 3'd5, 8'h66, 8'h51, 1'b1};
    vecs[15] = '{1'b1, 3'd6, 8'h12, 1'b1, 6'h05, 8'h00, 3'd6, 8'h12, 8'h72, 1'b1};
    vecs[16] = '{1'b0, 3'd0, 8'h00, 1'b1, 6'h00, 8'h00, 3'd7, 8'h77, 8'h10, 1'b0};

    nrst = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 6'h00, 8'h00);
    #12;
    chk("reset status", 64'(status), 64'h00);
    chk("reset cfg", 64'(cfg), 64'h0);
    chk("reset irq", 64'(irq), 64'h0);
    chk("reset rd_data", 64'(rd_data), 64'h00);
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vecs[i].wv, vecs[i].a, vecs[i].d, vecs[i].fv, vecs[i].fc, vecs[i].hw);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d status", i), 64'(status), 64'(vecs[i].est));
      chk($sformatf("v%0d irq", i), 64'(irq), 64'(vecs[i].eirq));
      chk($sformatf("v%0d cfg[%0d]", i, vecs[i].ci), 64'(cfg_byte(vecs[i].ci)), 64'(vecs[i].ecfg));
    end

    // Held write strobe: 17 accepted writes wrap the counter to 1.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(1'b1, 3'd1, 8'(i), 1'b0, 6'h00, 8'h00);
    end
    @(negedge clk);
    drive(1'b0, 3'd1, 8'h00, 1'b0, 6'h00, 8'h00);
    chk("wrap status", 64'(status), 64'h11);
    chk("wrap cfg[1]", 64'(cfg_byte(3'd1)), 64'h10);

    // Read latency of one cycle.
    @(negedge clk);
    chk("read reg1", 64'(rd_data), 64'h10);

    // Write then read of the same address.
    @(negedge clk);
    drive(1'b1, 3'd3, 8'h9C, 1'b0, 6'h00, 8'h00);
    @(negedge clk);
    wr_vld = 1'b0;
    chk("rd before write", 64'(rd_data), 64'h00);
    @(negedge clk);
    chk("rd after write", 64'(rd_data), 64'h9C);
    chk("wcnt after rd", 64'(status), 64'h12);

    // Address increments the cycle after the strobe.
    @(negedge clk);
    drive(1'b1, 3'd4, 8'h4D, 1'b0, 6'h00, 8'h00);
    @(negedge clk);
    drive(1'b0, 3'd5, 8'h4D, 1'b0, 6'h00, 8'h00);
    @(negedge clk);
    chk("incr cfg[4]", 64'(cfg_byte(3'd4)), 64'h4D);
    chk("incr cfg[5]", 64'(cfg_byte(3'd5)), 64'h00);
    chk("incr rd reg5", 64'(rd_data), 64'h00);

    // Async reset mid-operation with non-zero state and irq raised.
    @(negedge clk);
    drive(1'b1, 3'd7, 8'h01, 1'b0, 6'h00, 8'h00);
    @(negedge clk);
    drive(1'b0, 3'd3, 8'h00, 1'b0, 6'h00, 8'h00);
    chk("pre-rst irq", 64'(irq), 64'h1);
    chk("pre-rst status", 64'(status), 64'h53);
    @(negedge clk);
    chk("pre-rst rd", 64'(rd_data), 64'h9C);
    #2;
    nrst = 1'b0;
    #1;
    chk("async cfg", 64'(cfg), 64'h0);
    chk("async rd_data", 64'(rd_data), 64'h00);
    chk("async status", 64'(status), 64'h00);
    chk("async irq", 64'(irq), 64'h0);
    @(negedge clk);
    nrst = 1'b1;
    drive(1'b1, 3'd2, 8'h5A, 1'b0, 6'h00, 8'h00);
    @(negedge clk);
    wr_vld = 1'b0;
    chk("post-rst cfg[2]", 64'(cfg_byte(3'd2)), 64'h5A);
    chk("post-rst status", 64'(status), 64'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
